alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Operand-issue and retire stage directly upstream of alu_32bit.
- Accepts decoded instructions over a valid/ready handshake and reads an 8x32 register file.
- Registers op1/op2/opsel/mode into a single execute register that drives alu_32bit combinationally.
- Retires the ALU result and flags back into the register file and status register, and presents the result on a writeback port.

Parameters:
DWIDTH, 32, datapath width
NREGS, 8, register count
AWIDTH, 3, register address width (log2 NREGS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  instruction accepted when valid&ready
instr_op  in  4  {mode,opsel}, optype encoding
instr_rd  in  AWIDTH  destination register
instr_rs1  in  AWIDTH  source 1 -> op1
instr_rs2  in  AWIDTH  source 2 -> op2 when instr_imm_sel=0
instr_imm_sel  in  1  1: op2 = instr_imm
instr_imm  in  DWIDTH  immediate
alu_op1  out  DWIDTH  to alu_32bit op1
alu_op2  out  DWIDTH  to alu_32bit op2
alu_opsel  out  3  to alu_32bit opsel
alu_mode  out  1  to alu_32bit mode
alu_result  in  DWIDTH  from alu_32bit
alu_flags  in  4  {c,z,o,s} from alu_32bit
wb_valid  out  1  retiring result valid
wb_ready  in  1  downstream accepts retirement
wb_rd  out  AWIDTH  retiring destination
wb_data  out  DWIDTH  retiring value (= alu_result)
status  out  4  {c,z,o,s} of last retired op
illegal_cnt  out  8  count of dropped illegal ops, saturating

Behaviour:
- Reset (async, rst_n=0):
  - Execute register: e_valid=0, alu_op1=alu_op2=0, alu_opsel=0, alu_mode=0.
  - All registers 0; status=0; illegal_cnt=0.
  - Outputs during reset: wb_valid=0, wb_rd=0, wb_data=0, instr_ready=0.
- Handshake and pipeline:
  - instr_ready = rst released & (!e_valid | wb_ready).
  - On accept, operands are read and the execute register is loaded at the same edge; e_valid=1.
  - ALU is combinational, so wb_data = alu_result in the same cycle.
  - wb_valid = e_valid. Retirement occurs at the edge where wb_valid & wb_ready.
  - At retirement: rf[wb_rd] <= wb_data (skipped if wb_rd=0) and status <= alu_flags. e_valid clears unless a new instruction is accepted at the same edge.
  - Throughput: 1 op/cycle with wb_ready=1.
  - Backpressure: e_valid=1 & wb_ready=0 holds alu_* stable, instr_ready=0, no RF or status update.
- Register r0 reads 0; writes to r0 are discarded. status still updates on an r0 retirement.
- Read-after-retire: a source equal to the register retiring at the same edge gets the retiring value (forwarding, see Optional Feature).
- Illegal ops 4'h7, 4'hE, 4'hF:
  - Accepted (instr_ready unchanged), not loaded into the execute register, no RF write, no status update.
  - illegal_cnt++, saturating at 255.
  - If a legal op retires at the same edge, the execute register empties.
- Reset mid-operation: in-flight op discarded, no RF write; all state returns to reset values.

Optional Feature:
Macro ALU_ISSUE_FWD_EN.
- Defined: a source register equal to e_rd (e_valid=1, e_rd!=0) takes alu_result combinationally, so back-to-back dependent ops issue without bubble.
- Undefined: such a match forces instr_ready=0 until the producer retires. The dependent op issues the following cycle from the RF, adding a 1-cycle bubble. Results are identical either way.

Decomposition:
- Package alu_pkg:
  - optype enum (add=0, subwb=1, mov=2, sub=3, inc=4, dec=5, addinc=6, land=8, lor=9, lxor=A, lnot=B, move=C, lshl=D).
  - DWIDTH; flags struct {c,z,o,s}; function is_legal_op.
- Sub-module alu_regfile:
  - NREGS x DWIDTH, two async read ports, one sync write port.
  - r0 hardwired 0; async reset clears all registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with an op pending -> immediately wb_valid=0, status=0, illegal_cnt=0; after release, rf[all]=0.
- add r1=r0+imm 5, then add r2=r1+imm 7, wb_ready=1 -> wb_data 5 then 12, status=0000. With ALU_ISSUE_FWD_EN there is no bubble; without it, exactly one bubble cycle.
- add r1=r0+imm 0xEEEEEEEE, then addinc r3=r1+r1 -> alu_op1=alu_op2=0xEEEEEEEE; wb_data=0xDDDDDDDD (op1+op2+1) with ALU flags captured in status.
- wb_ready=0 for 3 cycles with an op in execute -> instr_ready=0, alu_* stable, rf unchanged. Retirement on the first wb_ready=1 edge; next op accepted at that same edge.
- instr_op=4'hF, then 256 further illegal ops -> no wb_valid, rf/status unchanged, illegal_cnt saturates at 255.
- add r0=r0+imm 9 -> wb_valid with wb_rd=0, wb_data=9, status updated; a subsequent read of r0 returns 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue/retire slice.
// Holds the datapath width, the {mode,opsel} operation encoding used by
// alu_32bit, the packed {c,z,o,s} flag layout and the opcode legality check.
package alu_pkg;

    localparam int unsigned DWIDTH = 32;

    // {mode,opsel} encodings understood by alu_32bit; 7, E and F are unused.
    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUBWB  = 4'h1,
        OP_MOV    = 4'h2,
        OP_SUB    = 4'h3,
        OP_INC    = 4'h4,
        OP_DEC    = 4'h5,
        OP_ADDINC = 4'h6,
        OP_LAND   = 4'h8,
        OP_LOR    = 4'h9,
        OP_LXOR   = 4'hA,
        OP_LNOT   = 4'hB,
        OP_MOVE   = 4'hC,
        OP_LSHL   = 4'hD
    } optype_e;

    typedef struct packed {
        logic c;
        logic z;
        logic o;
        logic s;
    } flags_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUBWB, OP_MOV, OP_SUB, OP_INC, OP_DEC, OP_ADDINC,
            OP_LAND, OP_LOR, OP_LXOR, OP_LNOT, OP_MOVE, OP_LSHL:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x DWIDTH register file, two asynchronous read ports and
// one synchronous write port. r0 always reads zero and ignores writes.
module alu_regfile #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr1_i,
    output logic [DWIDTH-1:0] rdata1_o,
    input  logic [AWIDTH-1:0] raddr2_i,
    output logic [DWIDTH-1:0] rdata2_o
);

    logic [DWIDTH-1:0] mem_q [NREGS];

    // Storage: cleared on reset, written on a retirement to a non-zero register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue and retire stage feeding alu_32bit.
// Reads operands from alu_regfile into a single execute register that drives
// the combinational ALU, then retires result/flags into the register file and
// status register over a valid/ready writeback port.
// Build option ALU_ISSUE_FWD_EN: when defined, a source matching the op in
// execute takes alu_result directly (no bubble); when undefined, such an op
// is held off for one cycle and reads the register file after retirement.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DWIDTH = alu_pkg::DWIDTH,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [AWIDTH-1:0] instr_rd,
    input  logic [AWIDTH-1:0] instr_rs1,
    input  logic [AWIDTH-1:0] instr_rs2,
    input  logic              instr_imm_sel,
    input  logic [DWIDTH-1:0] instr_imm,
    output logic [DWIDTH-1:0] alu_op1,
    output logic [DWIDTH-1:0] alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [AWIDTH-1:0] wb_rd,
    output logic [DWIDTH-1:0] wb_data,
    output logic [3:0]        status,
    output logic [7:0]        illegal_cnt
);

    // Execute register
    logic              e_valid_q, e_valid_d;
    logic [AWIDTH-1:0] e_rd_q, e_rd_d;
    logic [DWIDTH-1:0] op1_q, op1_d;
    logic [DWIDTH-1:0] op2_q, op2_d;
    logic [2:0]        opsel_q, opsel_d;
    logic              mode_q, mode_d;

    // Architectural status
    flags_t            status_q, status_d;
    logic [7:0]        ill_cnt_q, ill_cnt_d;

    // Issue/retire control
    logic              accept;
    logic              load;
    logic              retire;
    logic              stall;
    logic              hit1;
    logic              hit2;
    logic              rf_we;
    logic [DWIDTH-1:0] rf_rdata1;
    logic [DWIDTH-1:0] rf_rdata2;
    logic [DWIDTH-1:0] src1;
    logic [DWIDTH-1:0] src2;

    alu_regfile #(
        .DWIDTH (DWIDTH),
        .NREGS  (NREGS),
        .AWIDTH (AWIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (rf_we),
        .waddr_i  (e_rd_q),
        .wdata_i  (alu_result),
        .raddr1_i (instr_rs1),
        .rdata1_o (rf_rdata1),
        .raddr2_i (instr_rs2),
        .rdata2_o (rf_rdata2)
    );

    // Dependency detection against the op currently in execute (r0 never matches).
    assign hit1 = e_valid_q && (e_rd_q != '0) && (instr_rs1 == e_rd_q);
    assign hit2 = e_valid_q && (e_rd_q != '0) && !instr_imm_sel && (instr_rs2 == e_rd_q);

`ifdef ALU_ISSUE_FWD_EN
    // A dependent op can only be accepted at the producer's retire edge, so
    // alu_result is exactly the value the register file is about to take.
    assign stall = 1'b0;
    assign src1  = hit1 ? alu_result : rf_rdata1;
    assign src2  = instr_imm_sel ? instr_imm : (hit2 ? alu_result : rf_rdata2);
`else
    assign stall = hit1 || hit2;
    assign src1  = rf_rdata1;
    assign src2  = instr_imm_sel ? instr_imm : rf_rdata2;
`endif

    assign instr_ready = rst_n && (!e_valid_q || wb_ready) && !stall;
    assign accept      = instr_valid && instr_ready;
    assign load        = accept && is_legal_op(instr_op);
    assign retire      = e_valid_q && wb_ready;
    assign rf_we       = retire && (e_rd_q != '0);

    // Next state of the execute register: load wins over retire-empty.
    always_comb begin
        e_valid_d = e_valid_q;
        e_rd_d    = e_rd_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opsel_d   = opsel_q;
        mode_d    = mode_q;
        if (load) begin
            e_valid_d = 1'b1;
            e_rd_d    = instr_rd;
            op1_d     = src1;
            op2_d     = src2;
            opsel_d   = instr_op[2:0];
            mode_d    = instr_op[3];
        end else if (retire) begin
            e_valid_d = 1'b0;
        end
    end

    // Execute register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q <= 1'b0;
            e_rd_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            opsel_q   <= '0;
            mode_q    <= 1'b0;
        end else begin
            e_valid_q <= e_valid_d;
            e_rd_q    <= e_rd_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opsel_q   <= opsel_d;
            mode_q    <= mode_d;
        end
    end

    // Status capture on retirement and saturating count of dropped illegal ops.
    always_comb begin
        status_d  = status_q;
        ill_cnt_d = ill_cnt_q;
        if (retire) begin
            status_d = flags_t'(alu_flags);
        end
        if (accept && !is_legal_op(instr_op) && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + 8'd1;
        end
    end

    // Status and illegal-count storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q  <= '0;
            ill_cnt_q <= '0;
        end else begin
            status_q  <= status_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_opsel   = opsel_q;
    assign alu_mode    = mode_q;
    assign wb_valid    = e_valid_q;
    assign wb_rd       = e_rd_q;
    assign wb_data     = alu_result;
    assign status      = status_q;
    assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven bench with a writeback scoreboard.
// A small behavioural ALU stands in for alu_32bit; expected writeback
// values come from hand-computed constants in the vector table.
module tb_alu_issue_stage;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        imm_sel;
        logic [31:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] data;
        logic [3:0]  flags;
        bit          dep;
    } vec_t;

`ifdef ALU_ISSUE_FWD_EN
    localparam int BUB = 1;
`else
    localparam int BUB = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = '0;
    logic [2:0]  instr_rd = '0;
    logic [2:0]  instr_rs1 = '0;
    logic [2:0]  instr_rs2 = '0;
    logic        instr_imm_sel = 1'b0;
    logic [31:0] instr_imm = '0;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [2:0]  alu_opsel;
    logic        alu_mode;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  status;
    logic [7:0]  illegal_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    vec_t        sb[$];
    vec_t        cur_vec;
    vec_t        e_pop;
    vec_t        tbl[12];
    logic [3:0]  exp_status = '0;
    int          exp_ill = 0;
    logic [3:0]  ill_ops[3] = '{4'hF, 4'h7, 4'hE};

    alu_issue_stage #(
        .DWIDTH (32),
        .NREGS  (8),
        .AWIDTH (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs1     (instr_rs1),
        .instr_rs2     (instr_rs2),
        .instr_imm_sel (instr_imm_sel),
        .instr_imm     (instr_imm),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_opsel     (alu_opsel),
        .alu_mode      (alu_mode),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .status        (status),
        .illegal_cnt   (illegal_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for alu_32bit (only the ops the bench uses).
    logic [32:0] sum;
    logic        c_f;
    logic        o_f;
    always_comb begin
        sum = '0;
        c_f = 1'b0;
        o_f = 1'b0;
        alu_result = alu_op1;
        case ({alu_mode, alu_opsel})
            4'h0, 4'h6: begin
                sum = {1'b0, alu_op1} + {1'b0, alu_op2} + {32'd0, alu_opsel == 3'd6};
                alu_result = sum[31:0];
                c_f = sum[32];
                o_f = (alu_op1[31] == alu_op2[31]) && (sum[31] != alu_op1[31]);
            end
            4'h8: alu_result = alu_op1 & alu_op2;
            4'h9: alu_result = alu_op1 | alu_op2;
            4'hA: alu_result = alu_op1 ^ alu_op2;
            default: alu_result = alu_op1;
        endcase
        alu_flags = {c_f, alu_result == 32'd0, o_f, alu_result[31]};
    end

    function automatic bit tb_legal(input logic [3:0] op);
        return !(op == 4'h7 || op == 4'hE || op == 4'hF);
    endfunction

    function automatic vec_t mkv(input logic [3:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic [2:0] rs2,
                                 input logic imm_sel, input logic [31:0] imm,
                                 input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [31:0] data, input logic [3:0] flags,
                                 input bit dep);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm_sel = imm_sel;
        v.imm = imm; v.op1 = op1; v.op2 = op2; v.data = data; v.flags = flags;
        v.dep = dep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: runs between edges while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("status", {28'd0, status}, {28'd0, exp_status});
            chk("illegal_cnt", {24'd0, illegal_cnt}, exp_ill);
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_wb actual=wb_valid required=idle rd=%0d", wb_rd);
                end else begin
                    e_pop = sb.pop_front();
                    chk("wb_rd", {29'd0, wb_rd}, {29'd0, e_pop.rd});
                    chk("wb_data", wb_data, e_pop.data);
                    chk("alu_op1", alu_op1, e_pop.op1);
                    chk("alu_op2", alu_op2, e_pop.op2);
                    chk("alu_opsel_mode", {28'd0, alu_mode, alu_opsel}, {28'd0, e_pop.op});
                    exp_status = e_pop.flags;
                end
            end
            if (instr_valid && instr_ready) begin
                if (tb_legal(cur_vec.op)) sb.push_back(cur_vec);
                else if (exp_ill < 255) exp_ill++;
            end
        end
    end

    task automatic present(input vec_t v);
        cur_vec       = v;
        instr_op      = v.op;
        instr_rd      = v.rd;
        instr_rs1     = v.rs1;
        instr_rs2     = v.rs2;
        instr_imm_sel = v.imm_sel;
        instr_imm     = v.imm;
        instr_valid   = 1'b1;
    endtask

    task automatic issue(input vec_t v, output int acc);
        present(v);
        acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (instr_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=not_ready required=accept op=%h", v.op);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int acc;
    int prev_acc;

    initial begin
        //            op    rd    rs1   rs2   isel  imm           op1           op2           data          flags    dep
        tbl[0]  = mkv(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5,        32'd0,        32'd5,        32'd5,        4'b0000, 0);
        tbl[1]  = mkv(4'h0, 3'd2, 3'd1, 3'd0, 1'b1, 32'd7,        32'd5,        32'd7,        32'd12,       4'b0000, 1);
        tbl[2]  = mkv(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 32'hEEEEEEEE, 32'd0,        32'hEEEEEEEE, 32'hEEEEEEEE, 4'b0001, 0);
        tbl[3]  = mkv(4'h6, 3'd3, 3'd1, 3'd1, 1'b0, 32'd0,        32'hEEEEEEEE, 32'hEEEEEEEE, 32'hDDDDDDDD, 4'b1001, 1);
        tbl[4]  = mkv(4'hA, 3'd4, 3'd3, 3'd0, 1'b1, 32'hFFFFFFFF, 32'hDDDDDDDD, 32'hFFFFFFFF, 32'h22222222, 4'b0000, 1);
        tbl[5]  = mkv(4'h8, 3'd5, 3'd4, 3'd2, 1'b0, 32'd0,        32'h22222222, 32'd12,       32'd0,        4'b0100, 1);
        tbl[6]  = mkv(4'h9, 3'd6, 3'd5, 3'd0, 1'b1, 32'h80000000, 32'd0,        32'h80000000, 32'h80000000, 4'b0001, 1);
        tbl[7]  = mkv(4'h0, 3'd7, 3'd6, 3'd6, 1'b0, 32'd0,        32'h80000000, 32'h80000000, 32'd0,        4'b1110, 1);
        tbl[8]  = mkv(4'h0, 3'd0, 3'd0, 3'd0, 1'b1, 32'd9,        32'd0,        32'd9,        32'd9,        4'b0000, 0);
        tbl[9]  = mkv(4'h0, 3'd5, 3'd6, 3'd0, 1'b0, 32'd0,        32'h80000000, 32'd0,        32'h80000000, 4'b0001, 0);
        tbl[10] = mkv(4'h0, 3'd2, 3'd2, 3'd0, 1'b1, 32'd0,        32'd12,       32'd0,        32'd12,       4'b0000, 0);
        tbl[11] = mkv(4'h0, 3'd4, 3'd4, 3'd0, 1'b1, 32'd0,        32'h22222222, 32'd0,        32'h22222222, 4'b0000, 0);

        // Power-on reset values.
        #12;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
        chk("rst_status", {28'd0, status}, 32'd0);
        chk("rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: dependent chains, flags, r0 write/read, RF readback.
        prev_acc = 0;
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i], acc);
            if (i > 0) chk("issue_gap", acc - prev_acc, tbl[i].dep ? BUB : 1);
            prev_acc = acc;
        end
        drain();

        // Backpressure: op held in execute for 3 cycles, next op waits.
        wb_ready = 1'b0;
        issue(mkv(4'h0, 3'd3, 3'd0, 3'd0, 1'b1, 32'h11, 32'd0, 32'h11, 32'h11, 4'b0000, 0), acc);
        present(mkv(4'h0, 3'd6, 3'd0, 3'd0, 1'b1, 32'h22, 32'd0, 32'h22, 32'h22, 4'b0000, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", {31'd0, instr_ready}, 32'd0);
            chk("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("bp_op1", alu_op1, 32'd0);
            chk("bp_op2", alu_op2, 32'h11);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_same_edge", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        drain();
        issue(mkv(4'h0, 3'd1, 3'd3, 3'd0, 1'b1, 32'd0, 32'h11, 32'd0, 32'h11, 4'b0000, 0), acc);
        drain();

        // Illegal ops: first one lands on a legal retirement, then saturation.
        issue(mkv(4'h0, 3'd2, 3'd0, 3'd0, 1'b1, 32'd1, 32'd0, 32'd1, 32'd1, 4'b0000, 0), acc);
        for (int n = 0; n < 257; n++) begin
            issue(mkv(ill_ops[n % 3], 3'd1, 3'd0, 3'd0, 1'b1, 32'hDEAD, 32'd0, 32'd0, 32'd0, 4'b0000, 0), acc);
        end
        chk("ill_saturated", {24'd0, illegal_cnt}, 32'd255);
        chk("ill_no_wb", {31'd0, wb_valid}, 32'd0);
        issue(mkv(4'h0, 3'd6, 3'd2, 3'd0, 1'b1, 32'd0, 32'd1, 32'd0, 32'd1, 4'b0000, 0), acc);
        issue(mkv(4'h0, 3'd5, 3'd0, 3'd0, 1'b1, 32'h80000000, 32'd0, 32'h80000000, 32'h80000000, 4'b0001, 0), acc);
        drain();

        // Reset mid-cycle with an op stuck in execute.
        wb_ready = 1'b0;
        issue(mkv(4'h0, 3'd7, 3'd0, 3'd0, 1'b1, 32'h33, 32'd0, 32'h33, 32'h33, 4'b0000, 0), acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid_rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        chk("mid_rst_status", {28'd0, status}, 32'd0);
        chk("mid_rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        chk("mid_rst_wb_rd", {29'd0, wb_rd}, 32'd0);
        chk("mid_rst_op2", alu_op2, 32'd0);
        sb.delete();
        exp_status = '0;
        exp_ill    = 0;
        wb_ready   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All registers read back as zero after reset.
        for (int k = 1; k < 8; k++) begin
            issue(mkv(4'h0, 3'(k), 3'(k), 3'd0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0100, 0), acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
